// File: rtl/pulse_cdc_pkg.sv
// Shared types and sizing helpers for the pulse pacer that feeds pulse_toggle_sync.
package pulse_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } pacer_state_t;

    localparam int PACER_GAP_MIN = 2;

    // Smallest safe GAP_CYCLES for a toggle synchroniser with sync_stages flops,
    // where clk_ratio is ceil(f_in/f_out).
    function automatic int pacer_min_gap(input int sync_stages, input int clk_ratio);
        return (sync_stages + 2) * clk_ratio + 1;
    endfunction

endpackage

// File: rtl/pulse_cdc_pacer.sv
// Counts incoming event strobes and re-emits them one per GAP_CYCLES so that
// consecutive toggles never collide inside the downstream synchroniser.
//
//  state | meaning
//  IDLE  | nothing in flight; fires when enabled and events are pending
//  FIRE  | pulse_out high for exactly one cycle, one pending event consumed
//  GAP   | enforced quiet time, gap_q counts down to zero
module pulse_cdc_pacer
    import pulse_cdc_pkg::*;
#(
    parameter int GAP_CYCLES = 8,
    parameter int CNTR_W     = 4
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              pulse_in,
    input  logic              en,
    input  logic              flush,
    input  logic              clr_ovrflw,
    output logic              pulse_out,
    output logic [CNTR_W-1:0] pend_cnt,
    output logic              busy,
    output logic              ovrflw
);

    localparam int              GAP_EFF  = (GAP_CYCLES < PACER_GAP_MIN) ? PACER_GAP_MIN : GAP_CYCLES;
    localparam logic [7:0]      GAP_LOAD = 8'(GAP_EFF - 2);
    localparam logic [CNTR_W-1:0] CNT_MAX = '1;

    pacer_state_t      state_q;
    logic [7:0]        gap_q;
    logic [CNTR_W-1:0] cnt_q;
    logic [CNTR_W-1:0] cnt_d;
    logic              ovf_q;
    logic              fire;
    logic              lost;

    assign fire = (state_q == FIRE);

    always_comb begin
        cnt_d = cnt_q;
        lost  = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (pulse_in && fire) begin
            cnt_d = cnt_q;
        end else if (pulse_in) begin
            if (cnt_q == CNT_MAX) begin
                lost = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTR_W'(1);
            end
        end else if (fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNTR_W'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (lost) begin
                ovf_q <= 1'b1;
            end else if (clr_ovrflw) begin
                ovf_q <= 1'b0;
            end
            case (state_q)
                // A same-cycle flush empties the count, so never fire on it.
                IDLE: begin
                    if (en && (cnt_q != '0) && !flush) begin
                        state_q <= FIRE;
                    end
                end
                FIRE: begin
                    gap_q   <= GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_q == 8'd0) begin
                        state_q <= (en && (cnt_d != '0)) ? FIRE : IDLE;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulse_out = fire;
    assign pend_cnt  = cnt_q;
    assign busy      = (state_q != IDLE) || (cnt_q != '0);
    assign ovrflw    = ovf_q;

endmodule

// File: tb/tb_pulse_cdc_pacer.sv
// Self-checking bench for pulse_cdc_pacer: directed scenarios, randomized traffic
// against a behavioural model, and an end-to-end toggle-synchroniser chain.
module tb_pulse_cdc_pacer;

    localparam int GAP  = 8;
    localparam int CW   = 4;
    localparam int MAXC = 15;
    localparam int GAP2 = 13;

    logic in_clk   = 1'b0;
    logic out_clk  = 1'b0;
    logic in_rst_n = 1'b1;
    logic pulse_in = 1'b0, en = 1'b0, flush = 1'b0, clr_ovrflw = 1'b0;
    logic pulse_out, busy, ovrflw;
    logic [CW-1:0] pend_cnt;

    logic p2_in = 1'b0;
    logic p2_out, p2_busy, p2_ovf;
    logic [CW-1:0] p2_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;
    int pq[$];
    int last_p = -1;
    int peak = 0;

    always #5  in_clk  = ~in_clk;
    always #15 out_clk = ~out_clk;

    pulse_cdc_pacer #(.GAP_CYCLES(GAP), .CNTR_W(CW)) u_dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .pulse_in(pulse_in), .en(en),
        .flush(flush), .clr_ovrflw(clr_ovrflw), .pulse_out(pulse_out),
        .pend_cnt(pend_cnt), .busy(busy), .ovrflw(ovrflw)
    );

    pulse_cdc_pacer #(.GAP_CYCLES(GAP2), .CNTR_W(CW)) u_e2e (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .pulse_in(p2_in), .en(1'b1),
        .flush(1'b0), .clr_ovrflw(1'b0), .pulse_out(p2_out),
        .pend_cnt(p2_cnt), .busy(p2_busy), .ovrflw(p2_ovf)
    );

    // Toggle synchroniser with 2 sync stages into the slow domain
    logic tgl = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int dcnt = 0, p2cnt = 0;
    always @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) tgl <= 1'b0; else if (p2_out) tgl <= ~tgl;
    always @(posedge out_clk or negedge in_rst_n)
        if (!in_rst_n) begin s1 <= 0; s2 <= 0; s3 <= 0; end
        else begin s1 <= tgl; s2 <= s1; s3 <= s2; end
    always @(posedge out_clk) if (in_rst_n && (s2 != s3)) dcnt++;
    always @(negedge in_clk) if (p2_out) p2cnt++;

    always @(posedge in_clk) cyc++;

    // Behavioural model: pending events plus cycles elapsed since the last emission
    int m_pend = 0;
    bit m_fire = 0, m_idle = 1, m_ovf = 0;
    int m_since = 0;
    always @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            m_pend = 0; m_fire = 0; m_idle = 1; m_ovf = 0; m_since = 0;
        end else begin
            int np;
            bit nf, lost;
            lost = 0;
            if (flush) np = 0;
            else if (pulse_in && m_fire) np = m_pend;
            else if (pulse_in) begin
                if (m_pend == MAXC) begin np = MAXC; lost = 1; end
                else np = m_pend + 1;
            end else if (m_fire) np = m_pend - 1;
            else np = m_pend;
            if (lost) m_ovf = 1; else if (clr_ovrflw) m_ovf = 0;
            if (m_idle) nf = en && (m_pend != 0) && !flush;
            else if (m_since < GAP - 1) nf = 0;
            else nf = en && (np != 0);
            if (nf) begin m_fire = 1; m_since = 0; m_idle = 0; end
            else if (m_idle || m_since == GAP - 1) begin m_fire = 0; m_idle = 1; end
            else begin m_fire = 0; m_since++; end
            m_pend = np;
        end
    end

    always @(negedge in_clk) begin
        if (chk_on) begin
            tests++;
            if (pulse_out !== m_fire || int'(pend_cnt) != m_pend || busy !== (!m_idle || m_pend != 0) || ovrflw !== m_ovf) begin
                fails++;
                $display("FAIL model cyc=%0d got pulse=%b pend=%0d busy=%b ovf=%b expected pulse=%b pend=%0d busy=%b ovf=%b",
                         cyc, pulse_out, pend_cnt, busy, ovrflw, m_fire, m_pend, (!m_idle || m_pend != 0), m_ovf);
            end
        end
        if (!in_rst_n) last_p = -1;
        else if (pulse_out) begin
            pq.push_back(cyc);
            if (last_p >= 0) begin
                tests++;
                if (cyc - last_p < GAP) begin
                    fails++;
                    $display("FAIL spacing cyc=%0d got %0d expected >= %0d", cyc, cyc - last_p, GAP);
                end
            end
            last_p = cyc;
        end
        if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic pi, input logic e, input logic fl, input logic co);
        pulse_in = pi; en = e; flush = fl; clr_ovrflw = co;
        @(posedge in_clk);
        #1;
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) drv(0, e, 0, 0);
    endtask

    initial begin
        #1 in_rst_n = 1'b0;
        #2 chk_on = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        chk("rst_pulse", pulse_out, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovrflw, 0);
        in_rst_n = 1'b1;
        chk("min_gap_fn", pulse_cdc_pkg::pacer_min_gap(2, 3), 13);
        run(5, 1);

        // Single pulse: strobe at edge E, pulse in cycle after E+1, idle after E+GAP+1
        pq.delete();
        drv(1, 1, 0, 0);
        chk("single_pend1", pend_cnt, 1);
        chk("single_nopulse_early", pulse_out, 0);
        drv(0, 1, 0, 0);
        chk("single_pulse", pulse_out, 1);
        drv(0, 1, 0, 0);
        chk("single_pulse_end", pulse_out, 0);
        chk("single_pend0", pend_cnt, 0);
        run(GAP - 2, 1);
        chk("single_busy_hold", busy, 1);
        drv(0, 1, 0, 0);
        chk("single_busy_low", busy, 0);
        run(10, 1);
        chk("single_count", pq.size(), 1);

        // Burst of 5 back-to-back strobes
        pq.delete(); peak = 0;
        for (int i = 0; i < 5; i++) drv(1, 1, 0, 0);
        run(60, 1);
        chk("burst_count", pq.size(), 5);
        for (int i = 1; i < pq.size(); i++) chk("burst_spacing", pq[i] - pq[i-1], GAP);
        chk("burst_peak", peak, 4);
        chk("burst_ovf", ovrflw, 0);

        // Saturation with emission disabled
        for (int i = 0; i < 17; i++) drv(1, 0, 0, 0);
        drv(0, 0, 0, 0);
        chk("sat_pend", pend_cnt, 15);
        chk("sat_ovf", ovrflw, 1);
        drv(0, 0, 0, 1);
        chk("sat_clr", ovrflw, 0);
        pq.delete();
        run(15 * GAP + 10, 1);
        chk("sat_drain_count", pq.size(), 15);
        chk("sat_drain_pend", pend_cnt, 0);

        // Strobe coincident with FIRE at full count
        for (int i = 0; i < 15; i++) drv(1, 0, 0, 0);
        drv(0, 1, 0, 0);
        chk("conc_fire", pulse_out, 1);
        drv(1, 1, 0, 0);
        chk("conc_pend", pend_cnt, 15);
        chk("conc_ovf", ovrflw, 0);
        drv(0, 1, 0, 0);
        // Flush with strobe during GAP
        pq.delete();
        drv(1, 1, 1, 0);
        chk("flush_pend", pend_cnt, 0);
        chk("flush_gap_busy", busy, 1);
        run(20, 1);
        chk("flush_no_pulses", pq.size(), 0);
        chk("flush_idle", busy, 0);

        // Reset mid-GAP with 3 pending
        for (int i = 0; i < 4; i++) drv(1, 0, 0, 0);
        drv(0, 1, 0, 0);
        drv(0, 1, 0, 0);
        drv(0, 1, 0, 0);
        chk("rstgap_pend", pend_cnt, 3);
        #1 in_rst_n = 1'b0;
        #1;
        chk("rstgap_pulse", pulse_out, 0);
        chk("rstgap_pend0", pend_cnt, 0);
        chk("rstgap_busy", busy, 0);
        chk("rstgap_ovf", ovrflw, 0);
        @(posedge in_clk); #1 in_rst_n = 1'b1;
        pq.delete();
        run(30, 1);
        chk("rstgap_quiet", pq.size(), 0);
        drv(1, 1, 0, 0);
        run(5, 1);
        chk("rstgap_new", pq.size(), 1);
        run(10, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            drv($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 80,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        drv(0, 1, 1, 1);
        run(20, 1);

        // End-to-end through the toggle synchroniser
        chk("e2e_gap_sizing", GAP2, pulse_cdc_pkg::pacer_min_gap(2, 3));
        dcnt = 0; p2cnt = 0;
        for (int i = 0; i < 20; i++) begin
            p2_in = 1'b1;
            drv(0, 1, 0, 0);
            p2_in = 1'b0;
            run($urandom_range(0, 4), 1);
        end
        begin
            int w;
            w = 0;
            while (p2_busy && w < 2000) begin drv(0, 1, 0, 0); w++; end
            chk("e2e_drain_timeout", int'(w >= 2000), 0);
        end
        run(30, 1);
        chk("e2e_src_pulses", p2cnt, 20);
        chk("e2e_dst_pulses", dcnt, 20);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_cdc_pacer.md
# pulse_cdc_pacer

Source-domain pacing stage placed directly upstream of `pulse_toggle_sync`. It accepts event pulses in `in_clk` at any rate, including back-to-back. It counts them as pending and re-emits them one at a time, with a guaranteed minimum spacing. This prevents two toggles from cancelling inside the destination synchroniser window. Saturation is reported with a sticky overflow flag. The pending count is exported for status registers.

## Interface
- `GAP_CYCLES`, default 8: minimum `in_clk` cycles between consecutive `pulse_out` assertions.
  - Legal range 2..255.
  - Integrator sets it ≥ (NUM_SYNC_STAGES+2)·ceil(f_in/f_out)+1.
- `CNTR_W`, default 4: pending counter width.
  - Saturates at 2^CNTR_W−1.

- `in_clk`  in  1  source clock
- `in_rst_n`  in  1  reset, asynchronous, active-low
- `pulse_in`  in  1  event strobe, one event per high cycle
- `en`  in  1  emission enable; counting continues while low
- `flush`  in  1  synchronous clear of pending count
- `clr_ovrflw`  in  1  clears sticky overflow
- `pulse_out`  out  1  paced single-cycle pulse, to `pulse_toggle_sync.pulse_in`
- `pend_cnt`  out  CNTR_W  events pending (not yet emitted)
- `busy`  out  1  high when state ≠ IDLE or `pend_cnt` ≠ 0
- `ovrflw`  out  1  sticky, set on an event lost to saturation

## Operation
- FSM states: IDLE, FIRE, GAP. Reset state is IDLE.
- IDLE
  - Goes to FIRE when `en` is high and `pend_cnt` ≠ 0.
  - Otherwise stays in IDLE.
- FIRE
  - Lasts exactly 1 cycle. `pulse_out` = (state==FIRE).
  - `pend_cnt` decrements at the end of this cycle.
  - Loads `gap_cnt` = GAP_CYCLES−2 and goes to GAP.
- GAP
  - `gap_cnt` decrements each cycle.
  - At `gap_cnt`==0: goes to FIRE if `en` is high and the pending count after this cycle's update is nonzero; otherwise goes to IDLE.
- Pending count update, evaluated each cycle, highest priority first:
  - `flush`: count becomes 0. A same-cycle `pulse_in` is discarded.
  - `pulse_in` and fire in the same cycle: count unchanged.
  - `pulse_in` only: count increments.
    - At max: count stays at max and `ovrflw` sets.
  - Fire only: count decrements.
- `flush` does not abort a FIRE or GAP in progress. The gap is always honoured.
- `en` low
  - Does not truncate FIRE or GAP.
  - Blocks only the next transition into FIRE.
- `ovrflw`
  - Set has priority over `clr_ovrflw` in the same cycle.
  - Otherwise `clr_ovrflw` clears it.
- Count arithmetic is unsigned CNTR_W. It never wraps: saturates high, and cannot underflow because FIRE requires a nonzero count.

## Timing
- Reset values: `pulse_out`=0, `pend_cnt`=0, `busy`=0, `ovrflw`=0, `gap_cnt`=0, state IDLE.
- Asynchronous assert; deassertion is assumed synchronised by the parent.
- Latency, idle block: `pulse_in` sampled at edge n → `pend_cnt`=1 after edge n → `pulse_out` high for the cycle after edge n+1.
  - That is 2 cycles from strobe to pulse.
- Spacing: rising edges of `pulse_out` are exactly GAP_CYCLES apart while the backlog is nonzero and `en` is high. They are never closer.
- All outputs are registered or decoded directly from registers. No combinational path from inputs to outputs.
- Reset mid-GAP: everything returns to reset values immediately. Pending events are lost, and no partial pulse is produced.

## Structure
- Package `pulse_cdc_pkg` contains:
  - the `pacer_state_t` enum {IDLE, FIRE, GAP};
  - the constant `PACER_GAP_MIN`=2;
  - the function `pacer_min_gap(sync_stages, clk_ratio)` used by parents to size GAP_CYCLES.
- No sub-module; the gap counter is inline.
- The parent instantiates `pulse_cdc_pacer` followed by `pulse_toggle_sync`.

## Test plan
- Single pulse.
  - Stimulus: after reset, strobe `pulse_in` 1 cycle at edge 10.
  - Required: `pulse_out` high only in the cycle after edge 11; `pend_cnt` 1→0; `busy` low from edge 12+GAP_CYCLES−1.
- Burst with default GAP_CYCLES=8.
  - Stimulus: 5 back-to-back strobes.
  - Required: exactly 5 `pulse_out` pulses, 8 cycles apart; `pend_cnt` peaks at 4 (one is consumed by the first fire during the burst); `ovrflw` stays 0.
- Saturation with CNTR_W=4.
  - Stimulus: `en`=0, 17 strobes.
  - Required: `pend_cnt`=15, `ovrflw`=1.
  - Then `clr_ovrflw` → `ovrflw`=0; raise `en` → exactly 15 pulses.
- Concurrency.
  - Stimulus: `pulse_in` coincident with a FIRE cycle at `pend_cnt`=15.
  - Required: count stays 15, `ovrflw` stays 0.
  - Stimulus: `flush` coincident with `pulse_in` during GAP.
  - Required: count 0; the GAP completes; no further pulses.
- Reset.
  - Stimulus: assert `in_rst_n` low mid-GAP with `pend_cnt`=3.
  - Required: all outputs 0 immediately; no pulse after release until a new strobe.
- End-to-end.
  - Setup: chain into `pulse_toggle_sync`, NUM_SYNC_STAGES=2, out_clk = in_clk/3, GAP_CYCLES=13.
  - Stimulus: 20 random-spaced strobes.
  - Required: exactly 20 destination pulses.
